// File: rtl/tthbif_pkg.sv
// Shared definitions for the TTHBIF serializer / deserializer pair.
package tthbif_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tthbif_ser_state_e;

  localparam logic IDLE_LVL  = 1'b0;
  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tthbif_bit_timer.sv
// Bit-period divider: tick_o marks the last cycle of each BIT_DIV-cycle bit.
module tthbif_bit_timer
  import tthbif_pkg::*;
#(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = cnt_w(BIT_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);

  logic [CNT_W-1:0] r_div;

  assign tick_o = (r_div == LAST);

  // Count 0..BIT_DIV-1 while running; clear restarts a fresh bit period.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_div <= '0;
    end else if (run_i) begin
      r_div <= tick_o ? '0 : r_div + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tthbif_tx_serializer.sv
// Parallel-to-serial framer: start, LSB-first data, optional even parity, stop.
module tthbif_tx_serializer
  import tthbif_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BIT_DIV   = 1,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int unsigned BC_W = cnt_w(DATA_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  tthbif_ser_state_e r_state, w_state_n;
  logic [DATA_W-1:0] r_shreg, w_shreg_n;
  logic [BC_W-1:0]   r_bitcnt, w_bitcnt_n;
  logic              r_par, w_par_n;
  logic              r_tx, w_tx_n;
  logic              r_busy;
  logic              w_tick;
  logic              w_ready;
  logic              w_accept;

  tthbif_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (w_accept),
    .run_i   (r_state != IDLE),
    .tick_o  (w_tick)
  );

  assign w_ready      = en_i && ((r_state == IDLE) || ((r_state == STOP) && w_tick));
  assign w_accept     = valid_i && w_ready;
  assign ready_o      = w_ready;
  assign tx_o         = r_tx;
  assign busy_o       = r_busy;
  assign frame_done_o = (r_state == STOP) && w_tick;

  // State and datapath registers; reset drops any word in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_tx     <= IDLE_LVL;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_shreg  <= w_shreg_n;
      r_bitcnt <= w_bitcnt_n;
      r_par    <= w_par_n;
      r_tx     <= w_tx_n;
      r_busy   <= (w_state_n != IDLE);
    end
  end

  // Next-state and next line level; tx is precomputed so the line comes from a flop.
  always_comb begin
    w_state_n  = r_state;
    w_shreg_n  = r_shreg;
    w_bitcnt_n = r_bitcnt;
    w_par_n    = r_par;
    w_tx_n     = IDLE_LVL;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_n  = START;
          w_shreg_n  = data_i;
          w_par_n    = ^data_i;
          w_bitcnt_n = '0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_n  = DATA;
          w_bitcnt_n = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shreg_n = r_shreg >> 1;
          if (r_bitcnt == BC_LAST) begin
            w_state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_bitcnt_n = r_bitcnt + BC_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_n = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_accept) begin
            w_state_n  = START;
            w_shreg_n  = data_i;
            w_par_n    = ^data_i;
            w_bitcnt_n = '0;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    unique case (w_state_n)
      START:   w_tx_n = START_LVL;
      DATA:    w_tx_n = w_shreg_n[0];
      PARITY:  w_tx_n = w_par_n;
      STOP:    w_tx_n = STOP_LVL;
      default: w_tx_n = IDLE_LVL;
    endcase
  end

endmodule

// File: tb/tb_tthbif_tx_serializer.sv
// Directed bench for tthbif_tx_serializer: parity (BIT_DIV=1) and no-parity (BIT_DIV=4) builds.
module tb_tthbif_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_valid;
  logic [7:0] a_data;
  logic       a_ready, a_tx, a_busy, a_done;

  logic       b_rst, b_en, b_valid;
  logic [7:0] b_data;
  logic       b_ready, b_tx, b_busy, b_done;

  int checks   = 0;
  int failures = 0;

  tthbif_tx_serializer #(.DATA_W(8), .BIT_DIV(1), .PARITY_EN(1)) dut_a (
    .clk_i        (clk),
    .rst_i        (a_rst),
    .en_i         (a_en),
    .data_i       (a_data),
    .valid_i      (a_valid),
    .ready_o      (a_ready),
    .tx_o         (a_tx),
    .busy_o       (a_busy),
    .frame_done_o (a_done)
  );

  tthbif_tx_serializer #(.DATA_W(8), .BIT_DIV(4), .PARITY_EN(0)) dut_b (
    .clk_i        (clk),
    .rst_i        (b_rst),
    .en_i         (b_en),
    .data_i       (b_data),
    .valid_i      (b_valid),
    .ready_o      (b_ready),
    .tx_o         (b_tx),
    .busy_o       (b_busy),
    .frame_done_o (b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level of frame bit i (0=start, 1..8 data, 9 parity, 10 stop).
  function automatic logic fbit(input logic [7:0] w, input int i);
    if (i == 0) return 1'b1;
    if (i <= 8) return w[i-1];
    if (i == 9) return ^w;
    return 1'b0;
  endfunction

  bit exp_a5 [11] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0};

  // Frame decoder for the backpressure run on dut_a.
  logic       dec_en = 1'b0;
  int         dec_pos = 0;
  logic [7:0] dec_w = '0;
  logic [7:0] acc_q [$];
  logic [7:0] rx_q  [$];

  always @(negedge clk) begin
    if (dec_en && a_busy) begin
      if (dec_pos == 0) begin
        chk("dec_start", 32'(a_tx), 32'(1));
      end else if (dec_pos <= 8) begin
        dec_w[dec_pos-1] = a_tx;
      end else if (dec_pos == 9) begin
        chk("dec_parity", 32'(a_tx), 32'(^dec_w));
      end else begin
        chk("dec_stop", 32'(a_tx), 32'(0));
        chk("dec_done", 32'(a_done), 32'(1));
        rx_q.push_back(dec_w);
      end
      dec_pos = (dec_pos == 10) ? 0 : dec_pos + 1;
    end
  end

  initial begin
    int  sent;
    bit  will;
    bit  fin;

    a_rst = 1'b1; a_en = 1'b0; a_valid = 1'b0; a_data = '0;
    b_rst = 1'b1; b_en = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (2) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state
    chk("rst_tx",    32'(a_tx),    32'(0));
    chk("rst_busy",  32'(a_busy),  32'(0));
    chk("rst_done",  32'(a_done),  32'(0));
    chk("rst_ready", 32'(a_ready), 32'(0));
    chk("rst_b_tx",  32'(b_tx),    32'(0));

    // Single word 0xA5 with parity
    a_en = 1'b1; #1;
    chk("idle_ready", 32'(a_ready), 32'(1));
    a_data = 8'hA5; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk("a5_tx",   32'(a_tx),   32'(exp_a5[i]));
      chk("a5_busy", 32'(a_busy), 32'(1));
      chk("a5_done", 32'(a_done), 32'(i == 10));
      @(negedge clk);
    end
    chk("a5_after_busy", 32'(a_busy), 32'(0));
    chk("a5_after_tx",   32'(a_tx),   32'(0));

    // Back-to-back 0x01 then 0xFF with valid held high
    a_data = 8'h01; a_valid = 1'b1;
    chk("b2b_idle_ready", 32'(a_ready), 32'(1));
    @(negedge clk);
    a_data = 8'hFF;
    for (int i = 0; i < 11; i++) begin
      chk("b2b1_tx",    32'(a_tx),    32'(fbit(8'h01, i)));
      chk("b2b1_ready", 32'(a_ready), 32'(i == 10));
      @(negedge clk);
    end
    a_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk("b2b2_tx",   32'(a_tx),   32'(fbit(8'hFF, i)));
      chk("b2b2_busy", 32'(a_busy), 32'(1));
      @(negedge clk);
    end
    chk("b2b_end_busy",  32'(a_busy),  32'(0));
    chk("b2b_end_ready", 32'(a_ready), 32'(1));

    // BIT_DIV=4, no parity, 0x80: 4x1, 28x0, 4x1, 4x0
    b_en = 1'b1; #1;
    chk("div4_ready", 32'(b_ready), 32'(1));
    b_data = 8'h80; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("div4_tx",   32'(b_tx),   32'((i < 4) || (i >= 32 && i < 36)));
      chk("div4_done", 32'(b_done), 32'(i == 39));
      @(negedge clk);
    end
    chk("div4_end_busy", 32'(b_busy), 32'(0));

    // Reset mid-DATA of 0xFF; a word offered during reset is not taken
    a_data = 8'hFF; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_tx", 32'(a_tx), 32'(fbit(8'hFF, i)));
      @(negedge clk);
    end
    a_rst = 1'b1; a_data = 8'h3C; a_valid = 1'b1;
    @(negedge clk);
    chk("rstmid_tx0",   32'(a_tx),    32'(0));
    chk("rstmid_busy",  32'(a_busy),  32'(0));
    chk("rstmid_done",  32'(a_done),  32'(0));
    chk("rstmid_ready", 32'(a_ready), 32'(1));
    a_rst = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk("x3c_tx", 32'(a_tx), 32'(fbit(8'h3C, i)));
      @(negedge clk);
    end
    chk("x3c_end_busy", 32'(a_busy), 32'(0));

    // Disabled with valid high: no accept; enabling accepts immediately
    a_en = 1'b0; a_data = 8'h5A; a_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("dis_ready", 32'(a_ready), 32'(0));
      chk("dis_tx",    32'(a_tx),    32'(0));
      @(negedge clk);
    end
    a_en = 1'b1; #1;
    chk("en_ready", 32'(a_ready), 32'(1));
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk("x5a_tx", 32'(a_tx), 32'(fbit(8'h5A, i)));
      @(negedge clk);
    end

    // Backpressure: random valid, data changes only on accept
    dec_en = 1'b1;
    a_data = 8'($urandom);
    sent = 0; will = 1'b0; fin = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (will) begin
        acc_q.push_back(a_data);
        a_data = 8'($urandom);
        sent++;
      end
      if (sent >= 6) begin
        a_valid = 1'b0;
        if (!a_busy) fin = 1'b1;
      end else begin
        a_valid = 1'($urandom_range(0, 1));
      end
      will = a_valid && a_ready;
      if (!fin) @(negedge clk);
    end
    dec_en = 1'b0;
    chk("bp_finished", 32'(fin), 32'(1));
    chk("bp_count", 32'(rx_q.size()), 32'(acc_q.size()));
    for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++) begin
      chk("bp_word", 32'(rx_q[i]), 32'(acc_q[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
